// File: rtl/store_queue.sv
// store_queue: in-order write buffer steering SB/SH/SW stores to dmem and/or imem ports.
// Optional STORE_MISALIGN_TRAP_EN rejects misaligned SH/SW and raises sticky misalign_err. Rev 1.0
`default_nettype none

module store_queue #(
  parameter int DEPTH  = 4,
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        opcode,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  input  logic              stall,
  output logic              accept,
  output logic              full,
  output logic              empty,
  output logic [MEM_AW-1:0] dmem_addr,
  output logic [MEM_AW-1:0] imem_addr,
  output logic [31:0]       dmem_din,
  output logic [31:0]       imem_din,
  output logic [3:0]        dmem_we,
  output logic [3:0]        imem_we,
  input  logic              dmem_ready,
  input  logic              imem_ready,
  output logic              misalign_err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [5:0] OP_SB = 6'h28;
  localparam logic [5:0] OP_SH = 6'h29;
  localparam logic [5:0] OP_SW = 6'h2B;

  typedef struct packed {
    logic              dhit;
    logic              ihit;
    logic [3:0]        mask;
    logic [MEM_AW-1:0] waddr;
    logic [31:0]       data;
  } entry_t;

  entry_t          q [DEPTH];
  entry_t          new_entry;
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic            is_sb;
  logic            is_sh;
  logic            is_sw;
  logic            is_store;
  logic            misaligned;
  logic            retire;
  logic            unused_addr;

  // Only the region nibble and the word-address slice matter; the rest is intentionally ignored.
  assign unused_addr = ^addr;

  assign is_sb    = (opcode == OP_SB);
  assign is_sh    = (opcode == OP_SH);
  assign is_sw    = (opcode == OP_SW);
  assign is_store = is_sb | is_sh | is_sw;

`ifdef STORE_MISALIGN_TRAP_EN
  assign misaligned = (is_sh & addr[0]) | (is_sw & (addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    new_entry       = '0;
    new_entry.dhit  = ~addr[31] & addr[28];
    new_entry.ihit  = ~addr[31] & addr[29];
    new_entry.waddr = addr[MEM_AW+1:2];
    if (is_sb) begin
      new_entry.mask = 4'b1000 >> addr[1:0];
      new_entry.data = {4{store_data[7:0]}};
    end else if (is_sh) begin
      new_entry.mask = addr[1] ? 4'b0011 : 4'b1100;
      new_entry.data = {2{store_data[15:0]}};
    end else begin
      new_entry.mask = 4'b1111;
      new_entry.data = store_data;
    end
  end

  assign full   = (count == (PW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign accept = ~rst & is_store & (new_entry.dhit | new_entry.ihit) & ~stall & ~full & ~misaligned;

  assign head   = q[rd_ptr];
  // A dual-hit head only leaves once both memories take it in the same cycle.
  assign retire = ~empty & (~head.dhit | dmem_ready) & (~head.ihit | imem_ready);

  assign dmem_addr = head.waddr;
  assign imem_addr = head.waddr;
  assign dmem_din  = head.data;
  assign imem_din  = head.data;
  assign dmem_we   = (~empty & head.dhit) ? head.mask : 4'b0000;
  assign imem_we   = (~empty & head.ihit) ? head.mask : 4'b0000;

  always_ff @(posedge clk) begin
    if (accept) begin
      q[wr_ptr] <= new_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (retire) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({accept, retire})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef STORE_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_err <= 1'b0;
    end else if (is_store & misaligned & ~stall) begin
      misalign_err <= 1'b1;
    end
  end
`else
  assign misalign_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_store_queue.sv
// tb_store_queue: directed vector table plus fill/drain and reset-flush sequences for store_queue.
`default_nettype none

module tb_store_queue;

  localparam logic [5:0] NOP = 6'h00;
  localparam logic [5:0] SB  = 6'h28;
  localparam logic [5:0] SH  = 6'h29;
  localparam logic [5:0] SW  = 6'h2B;
`ifdef STORE_MISALIGN_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic        accept, full, empty;
  logic [11:0] dmem_addr, imem_addr;
  logic [31:0] dmem_din, imem_din;
  logic [3:0]  dmem_we, imem_we;
  logic        dmem_ready, imem_ready;
  logic        misalign_err;

  always #5 clk = ~clk;

  store_queue #(.DEPTH(4), .MEM_AW(12)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .addr(addr), .store_data(store_data),
    .stall(stall), .accept(accept), .full(full), .empty(empty),
    .dmem_addr(dmem_addr), .imem_addr(imem_addr), .dmem_din(dmem_din), .imem_din(imem_din),
    .dmem_we(dmem_we), .imem_we(imem_we), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
    .misalign_err(misalign_err)
  );

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] d;
    logic        st, dr, ir;
    logic        e_acc, e_emp, e_ful;
    logic [3:0]  e_dwe, e_iwe;
    logic [31:0] e_din;
    logic [11:0] e_adr;
    logic        e_err;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                     input logic st, input logic dr, input logic ir,
                     input logic acc, input logic emp, input logic ful,
                     input logic [3:0] dwe, input logic [3:0] iwe,
                     input logic [31:0] din, input logic [11:0] adr, input logic err);
    vec_t v;
    v.op = op; v.a = a; v.d = d; v.st = st; v.dr = dr; v.ir = ir;
    v.e_acc = acc; v.e_emp = emp; v.e_ful = ful; v.e_dwe = dwe; v.e_iwe = iwe;
    v.e_din = din; v.e_adr = adr; v.e_err = err;
    vq.push_back(v);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later, before the next rising edge.
  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic st, input logic dr, input logic ir);
    @(negedge clk);
    opcode = op; addr = a; store_data = d; stall = st; dmem_ready = dr; imem_ready = ir;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    opcode = NOP; addr = '0; store_data = '0; stall = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1;
    drive(NOP, 0, 0, 0, 1, 1);
    drive(NOP, 0, 0, 0, 1, 1);
    rst = 1'b0;

    //   op   addr          data          st dr ir  acc emp ful dwe      iwe      din           adr    err
    add(NOP, 32'h0,        32'h0,        0, 1, 1,  0,  1,  0,  4'b0000, 4'b0000, 32'h0,        12'd0, 0);
    add(SB,  32'h1000_0003, 32'h0000_00AB, 0, 1, 1, 1,  1,  0,  4'b0000, 4'b0000, 32'h0,        12'd0, 0);
    add(NOP, 32'h0,        32'h0,        0, 1, 1,  0,  0,  0,  4'b0001, 4'b0000, 32'hABABABAB, 12'd0, 0);
    add(NOP, 32'h0,        32'h0,        0, 1, 1,  0,  1,  0,  4'b0000, 4'b0000, 32'h0,        12'd0, 0);
    add(SW,  32'h8000_0000, 32'h1111_1111, 0, 1, 1, 0,  1,  0,  4'b0000, 4'b0000, 32'h0,        12'd0, 0);
    add(SW,  32'h1000_0000, 32'h2222_2222, 1, 1, 1, 0,  1,  0,  4'b0000, 4'b0000, 32'h0,        12'd0, 0);
    add(NOP, 32'h0,        32'h0,        0, 1, 1,  0,  1,  0,  4'b0000, 4'b0000, 32'h0,        12'd0, 0);
    add(SH,  32'h3000_0002, 32'h0000_1234, 0, 1, 0, 1,  1,  0,  4'b0000, 4'b0000, 32'h0,        12'd0, 0);
    for (int k = 0; k < 3; k++)
      add(NOP, 32'h0,      32'h0,        0, 1, 0,  0,  0,  0,  4'b0011, 4'b0011, 32'h12341234, 12'd0, 0);
    add(NOP, 32'h0,        32'h0,        0, 1, 1,  0,  0,  0,  4'b0011, 4'b0011, 32'h12341234, 12'd0, 0);
    add(NOP, 32'h0,        32'h0,        0, 1, 1,  0,  1,  0,  4'b0000, 4'b0000, 32'h0,        12'd0, 0);
    add(SW,  32'h1000_0002, 32'hDEAD_BEEF, 0, 1, 1, ~TRAP, 1, 0, 4'b0000, 4'b0000, 32'h0,       12'd0, 0);
    add(NOP, 32'h0,        32'h0,        0, 1, 1,  0, TRAP, 0, TRAP ? 4'b0000 : 4'b1111, 4'b0000, 32'hDEADBEEF, 12'd0, TRAP);
    add(NOP, 32'h0,        32'h0,        0, 1, 1,  0,  1,  0,  4'b0000, 4'b0000, 32'h0,        12'd0, TRAP);
    add(SB,  32'h2000_0005, 32'h0000_005A, 0, 1, 1, 1,  1,  0,  4'b0000, 4'b0000, 32'h0,        12'd0, TRAP);
    add(NOP, 32'h0,        32'h0,        0, 1, 1,  0,  0,  0,  4'b0000, 4'b0100, 32'h5A5A5A5A, 12'd1, TRAP);
    add(NOP, 32'h0,        32'h0,        0, 1, 1,  0,  1,  0,  4'b0000, 4'b0000, 32'h0,        12'd0, TRAP);

    foreach (vq[i]) begin
      drive(vq[i].op, vq[i].a, vq[i].d, vq[i].st, vq[i].dr, vq[i].ir);
      check($sformatf("v%0d accept", i), 32'(accept), 32'(vq[i].e_acc));
      check($sformatf("v%0d empty", i), 32'(empty), 32'(vq[i].e_emp));
      check($sformatf("v%0d full", i), 32'(full), 32'(vq[i].e_ful));
      check($sformatf("v%0d dmem_we", i), 32'(dmem_we), 32'(vq[i].e_dwe));
      check($sformatf("v%0d imem_we", i), 32'(imem_we), 32'(vq[i].e_iwe));
      check($sformatf("v%0d misalign_err", i), 32'(misalign_err), 32'(vq[i].e_err));
      if ((vq[i].e_dwe | vq[i].e_iwe) != 4'b0000) begin
        check($sformatf("v%0d dmem_din", i), dmem_din, vq[i].e_din);
        check($sformatf("v%0d imem_din", i), imem_din, vq[i].e_din);
        check($sformatf("v%0d dmem_addr", i), 32'(dmem_addr), 32'(vq[i].e_adr));
        check($sformatf("v%0d imem_addr", i), 32'(imem_addr), 32'(vq[i].e_adr));
      end
    end

    // Fill with dmem stalled: fifth store refused, queue full.
    for (int i = 0; i < 5; i++) begin
      drive(SW, 32'h1000_0000 + 32'(4 * i), 32'h100 + 32'(i), 0, 0, 1);
      check($sformatf("fill%0d accept", i), 32'(accept), (i < 4) ? 32'd1 : 32'd0);
    end
    check("fill full", 32'(full), 32'd1);
    check("fill held we", 32'(dmem_we), 32'hF);
    check("fill held addr", 32'(dmem_addr), 32'd0);

    // Full while head retires: still refused.
    drive(SW, 32'h1000_0020, 32'h2AA, 0, 1, 1);
    check("full+retire accept", 32'(accept), 32'd0);
    check("full+retire full", 32'(full), 32'd1);
    check("drain0 addr", 32'(dmem_addr), 32'd0);
    check("drain0 din", dmem_din, 32'h100);

    // Accept and retire together; new entry lands in the wrapped slot.
    drive(SW, 32'h1000_0014, 32'h1FF, 0, 1, 1);
    check("acc+ret accept", 32'(accept), 32'd1);
    check("acc+ret full", 32'(full), 32'd0);
    check("drain1 addr", 32'(dmem_addr), 32'd1);
    check("drain1 din", dmem_din, 32'h101);

    begin
      logic [11:0] ea [3];
      logic [31:0] ed [3];
      ea[0] = 12'd2; ea[1] = 12'd3; ea[2] = 12'd5;
      ed[0] = 32'h102; ed[1] = 32'h103; ed[2] = 32'h1FF;
      for (int i = 0; i < 3; i++) begin
        drive(NOP, 0, 0, 0, 1, 1);
        check($sformatf("drain%0d we", i + 2), 32'(dmem_we), 32'hF);
        check($sformatf("drain%0d addr", i + 2), 32'(dmem_addr), 32'(ea[i]));
        check($sformatf("drain%0d din", i + 2), dmem_din, ed[i]);
      end
    end
    drive(NOP, 0, 0, 0, 1, 1);
    check("drained empty", 32'(empty), 32'd1);
    check("drained we", 32'(dmem_we), 32'd0);

    // Reset flushes queued stores without writing them.
    drive(SW, 32'h1000_0000, 32'h5555_5555, 0, 0, 0);
    drive(SB, 32'h3000_0001, 32'h0000_0066, 0, 0, 0);
    drive(SH, 32'h2000_0002, 32'h0000_7777, 0, 0, 0);
    drive(NOP, 0, 0, 0, 0, 0);
    check("pre-rst empty", 32'(empty), 32'd0);
    rst = 1'b1;
    drive(NOP, 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(NOP, 0, 0, 0, 1, 1);
      check($sformatf("post-rst%0d empty", i), 32'(empty), 32'd1);
      check($sformatf("post-rst%0d full", i), 32'(full), 32'd0);
      check($sformatf("post-rst%0d accept", i), 32'(accept), 32'd0);
      check($sformatf("post-rst%0d dmem_we", i), 32'(dmem_we), 32'd0);
      check($sformatf("post-rst%0d imem_we", i), 32'(imem_we), 32'd0);
      check($sformatf("post-rst%0d err", i), 32'(misalign_err), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set queue entries; power of two, >=2.
REQ-002 Parameter MEM_AW, default 12, SHALL set word-address width of each memory port.
REQ-003 clk  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 opcode  input  6  SHALL carry the instruction opcode: SB=6'h28, SH=6'h29, SW=6'h2B; others are non-stores.
REQ-006 addr  input  32  SHALL carry the byte address of the store (ALU result).
REQ-007 store_data  input  32  SHALL carry the rt register value, valid with opcode.
REQ-008 stall  input  1  SHALL, when high, suppress acceptance of the presented store.
REQ-009 accept  output  1  SHALL be high in any cycle the presented store is enqueued.
REQ-010 full / empty  output  1 each  SHALL indicate count==DEPTH / count==0.
REQ-011 dmem_addr, imem_addr  output  MEM_AW each  SHALL carry word address addr[MEM_AW+1:2] of the head entry.
REQ-012 dmem_din, imem_din  output  32 each  SHALL carry head-entry lane-replicated data.
REQ-013 dmem_we, imem_we  output  4 each  SHALL carry byte write enables, bit3 = byte offset 0.
REQ-014 dmem_ready, imem_ready  input  1 each  SHALL indicate the target memory consumes the presented write this cycle.
REQ-015 misalign_err  output  1  SHALL be the sticky misalignment flag (REQ-030).

Function
REQ-016 Region decode SHALL use addr[31:28]: dmem hit when bit31==0 and bit28==1; imem hit when bit31==0 and bit29==1; both may hit.
REQ-017 A store SHALL be accepted when opcode is SB/SH/SW, at least one region hits, stall==0, full==0; otherwise accept==0 and nothing is recorded.
REQ-018 Stores hitting no region SHALL be dropped silently.
REQ-019 Entry SHALL hold {dmem_hit, imem_hit, mask, word address, data}.
REQ-020 Mask: SB offset 00/01/10/11 -> 1000/0100/0010/0001; SH offset[1] 0/1 -> 1100/0011; SW -> 1111.
REQ-021 Data: SB replicates store_data[7:0] in all four lanes; SH replicates [15:0] in both halves; SW unchanged.
REQ-022 When non-empty, head entry SHALL drive each hit port's we with its mask; non-hit ports and an empty queue SHALL drive we=4'b0.
REQ-023 Head SHALL retire in the first cycle all its hit ports have ready==1 in the same cycle; a dual-hit entry waits for both.
REQ-024 Latency: store accepted at edge N SHALL appear on its port(s) in the cycle after edge N when the queue was empty.
REQ-025 Entries SHALL drain strictly in acceptance order, at most one per cycle.
REQ-026 Simultaneous accept and retire SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-027 When full, accept SHALL be 0 even if the head retires that cycle.
REQ-028 Port outputs other than we SHALL hold head values while we==0 (don't-care to memories).

Reset
REQ-029 rst SHALL zero count and both pointers and clear misalign_err; outputs on the following cycle: empty=1, full=0, accept=0, all we=0; queued stores are discarded mid-operation without draining.

Configuration
REQ-030 Macro STORE_MISALIGN_TRAP_EN defined: SH with addr[0]==1 or SW with addr[1:0]!=0 SHALL not be accepted and SHALL set misalign_err until rst. Undefined: low offset bits ignored per REQ-020, misalign_err tied 0.

Verification
REQ-031 SB addr=0x1000_0003 data=0xAB, ready=1 -> next cycle dmem_we=0001, dmem_din=0xABABABAB, imem_we=0000, then empty=1.
REQ-032 Hold dmem_ready=0, issue 5 SW to 0x1000_0000..0x1000_0010, DEPTH=4 -> accept high for first 4 only, full=1; release ready -> words drain in order, one per cycle.
REQ-033 SH addr=0x3000_0002 data=0x1234, dmem_ready=1 and imem_ready=0 for 3 cycles -> both ports we=0011, din=0x12341234, entry held until imem_ready=1.
REQ-034 SW addr=0x8000_0000 or stall=1 -> accept=0, empty stays 1.
REQ-035 Three stores queued with ready=0, rst=1 for one cycle -> empty=1, all we=0, nothing written after ready=1.
REQ-036 With STORE_MISALIGN_TRAP_EN, SW addr=0x1000_0002 -> accept=0, misalign_err=1 until rst; without it, dmem_we=1111 at word 0x1000_0000.
